// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional hold buffer is selected with the FETCH_SKID_BUF_EN macro.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 13;
  localparam int INSTR_W_DEF = 16;

  // Value presented on the IF/ID instruction field while it is invalid after reset
  localparam logic [15:0] INSTR_NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Bundle of PC, instruction-memory, hazard and IF/ID signals around the fetch stage.
// The master side is the fetch stage itself; the slave side is its environment.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               start;
  logic [ADDR_W-1:0]  pc_in;
  logic [ADDR_W-1:0]  pc_next;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  br_target;
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc;

  modport master (
    input  start, pc_in, imem_ack, imem_rdata, stall, flush, br_target,
    output pc_next, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );

  modport slave (
    output start, pc_in, imem_ack, imem_rdata, stall, flush, br_target,
    input  pc_next, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry hold buffer that parks a fetched word while ID is stalled.
// Only instantiated when FETCH_SKID_BUF_EN is defined.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  // Clear wins over load so a discarded word never survives a flush or stop
  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      valid_q <= 1'b0;
      instr_q <= {INSTR_W{1'b0}};
      pc_q    <= {ADDR_W{1'b0}};
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else begin
      valid_q <= valid_q;
      instr_q <= instr_q;
      pc_q    <= pc_q;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem requests, fills IF/ID and computes the next PC.
// FETCH_SKID_BUF_EN adds a HOLD state that parks a word acked during a stall.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  fetch_state_e       state_q, state_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0]  pc_next_s;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic               imem_req_s;

  assign pc_inc_s = bus.pc_in + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef FETCH_SKID_BUF_EN
  logic               buf_load_s;
  logic               buf_clear_s;
  logic               buf_valid_s;
  logic [INSTR_W-1:0] buf_instr_s;
  logic [ADDR_W-1:0]  buf_pc_s;

  assign buf_load_s  = reset && !bus.flush && bus.start && (state_q == ST_REQ)
                       && bus.imem_ack && bus.stall;
  assign buf_clear_s = bus.flush || !bus.start || ((state_q == ST_HOLD) && !bus.stall);

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load_s),
    .clear_i (buf_clear_s),
    .instr_i (bus.imem_rdata),
    .pc_i    (bus.pc_in),
    .valid_o (buf_valid_s),
    .instr_o (buf_instr_s),
    .pc_o    (buf_pc_s)
  );
`endif

  // Next state, next PC and IF/ID load decisions; flush outranks start, start outranks state
  always_comb begin
    state_d      = state_q;
    pc_next_s    = bus.pc_in;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    imem_req_s   = reset && (state_q == ST_REQ);
    if (!reset) begin
      state_d   = ST_IDLE;
      pc_next_s = {ADDR_W{1'b0}};
    end else if (bus.flush) begin
      pc_next_s    = bus.br_target;
      ifid_valid_d = 1'b0;
      state_d      = bus.start ? ST_REQ : ST_IDLE;
    end else if (!bus.start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (bus.imem_ack && !bus.stall) begin
            pc_next_s    = pc_inc_s;
            ifid_valid_d = 1'b1;
            ifid_instr_d = bus.imem_rdata;
            ifid_pc_d    = bus.pc_in;
          end else if (bus.imem_ack) begin
`ifdef FETCH_SKID_BUF_EN
            pc_next_s = pc_inc_s;
            state_d   = ST_HOLD;
`else
            // No buffer: drop the word and refetch the same address once ID frees up
            state_d   = ST_REQ;
`endif
          end else begin
            state_d = ST_REQ;
          end
        end
`ifdef FETCH_SKID_BUF_EN
        ST_HOLD: begin
          if (!bus.stall) begin
            ifid_valid_d = buf_valid_s;
            ifid_instr_d = buf_instr_s;
            ifid_pc_d    = buf_pc_s;
            state_d      = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= INSTR_W'(INSTR_NOP);
      ifid_pc_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  assign bus.pc_next    = pc_next_s;
  assign bus.imem_req   = imem_req_s;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a cycle-level reference model.
// Works with or without FETCH_SKID_BUF_EN.
module tb_fetch_stage;

`ifdef FETCH_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_HOLD = 2;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fetch_if #(.ADDR_W(13), .INSTR_W(16)) bus ();

  fetch_stage #(.ADDR_W(13), .INSTR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_st;
  bit          m_v;
  logic [15:0] m_instr;
  logic [12:0] m_pc;
  bit          m_bv;
  logic [15:0] m_binstr;
  logic [12:0] m_bpc;
  logic [12:0] last_pcn;
  logic [12:0] obs_pcn;
  logic        obs_req;

  // One clock cycle: inputs already driven; check comb outputs, advance model, check IF/ID
  task automatic tick(input string tag);
    logic [12:0] e_pcn;
    logic        e_req;
    logic        r, st, ak, sl, fl;
    logic [12:0] pci, bt;
    logic [15:0] rd;
    #1;
    r = reset; st = bus.start; ak = bus.imem_ack; sl = bus.stall; fl = bus.flush;
    pci = bus.pc_in; bt = bus.br_target; rd = bus.imem_rdata;
    e_req = r && (m_st == M_REQ);
    if (!r) e_pcn = 13'd0;
    else if (fl) e_pcn = bt;
    else if (st && m_st == M_REQ && ak && (!sl || SKID)) e_pcn = pci + 13'd1;
    else e_pcn = pci;
    obs_pcn = bus.pc_next;
    obs_req = bus.imem_req;
    checks++;
    if (bus.pc_next !== e_pcn) begin
      failures++;
      $display("FAIL %s pc_next got=%h exp=%h", tag, bus.pc_next, e_pcn);
    end
    checks++;
    if (bus.imem_req !== e_req) begin
      failures++;
      $display("FAIL %s imem_req got=%b exp=%b", tag, bus.imem_req, e_req);
    end
    checks++;
    if (bus.imem_addr !== pci) begin
      failures++;
      $display("FAIL %s imem_addr got=%h exp=%h", tag, bus.imem_addr, pci);
    end
    last_pcn = e_pcn;
    @(posedge clk);
    if (!r) begin
      m_st = M_IDLE; m_v = 1'b0; m_instr = 16'h0000; m_pc = 13'd0; m_bv = 1'b0;
    end else if (fl) begin
      m_v = 1'b0; m_bv = 1'b0; m_st = st ? M_REQ : M_IDLE;
    end else if (!st) begin
      m_bv = 1'b0; m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      m_st = M_REQ;
    end else if (m_st == M_REQ) begin
      if (ak && !sl) begin
        m_v = 1'b1; m_instr = rd; m_pc = pci;
      end else if (ak && SKID) begin
        m_bv = 1'b1; m_binstr = rd; m_bpc = pci; m_st = M_HOLD;
      end
    end else if (m_st == M_HOLD && !sl) begin
      m_v = 1'b1; m_instr = m_binstr; m_pc = m_bpc; m_bv = 1'b0; m_st = M_REQ;
    end
    @(negedge clk);
    checks++;
    if (bus.ifid_valid !== m_v || bus.ifid_instr !== m_instr || bus.ifid_pc !== m_pc) begin
      failures++;
      $display("FAIL %s ifid got=%b/%h/%h exp=%b/%h/%h", tag, bus.ifid_valid,
               bus.ifid_instr, bus.ifid_pc, m_v, m_instr, m_pc);
    end
  endtask

  task automatic drive(input logic st, input logic [12:0] pc, input logic ak,
                       input logic [15:0] rd, input logic sl, input logic fl,
                       input logic [12:0] bt);
    bus.start = st; bus.pc_in = pc; bus.imem_ack = ak; bus.imem_rdata = rd;
    bus.stall = sl; bus.flush = fl; bus.br_target = bt;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 13'($urandom), 1'b1, 16'($urandom), 1'b0, 1'b0, 13'd0);
      tick("reset");
    end
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0000 || bus.ifid_pc !== 13'd0) begin
      failures++;
      $display("FAIL reset_ifid got=%b/%h/%h exp=0/0000/0000", bus.ifid_valid, bus.ifid_instr, bus.ifid_pc);
    end
  endtask

  task automatic test_first_fetch();
    reset = 1'b1;
    drive(1'b1, 13'd0, 1'b1, 16'hA001, 1'b0, 1'b0, 13'd0);
    tick("first_idle");
    tick("first_ack");
    checks++;
    if (obs_pcn !== 13'd1) begin
      failures++;
      $display("FAIL first_pcnext got=%h exp=0001", obs_pcn);
    end
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 16'hA001 || bus.ifid_pc !== 13'd0) begin
      failures++;
      $display("FAIL first_ifid got=%b/%h/%h exp=1/a001/0000", bus.ifid_valid, bus.ifid_instr, bus.ifid_pc);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 13'h1FFF, 1'b1, 16'h5A5A, 1'b0, 1'b0, 13'd0);
    tick("wrap");
    checks++;
    if (obs_pcn !== 13'd0 || bus.ifid_pc !== 13'h1FFF) begin
      failures++;
      $display("FAIL wrap got pcn=%h ifid_pc=%h exp pcn=0000 ifid_pc=1fff", obs_pcn, bus.ifid_pc);
    end
  endtask

  task automatic test_stall();
    logic [15:0] sv_instr;
    logic [12:0] sv_pc;
    sv_instr = bus.ifid_instr;
    sv_pc    = bus.ifid_pc;
    drive(1'b1, 13'd5, 1'b1, 16'h1234, 1'b1, 1'b0, 13'd0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      if (i == 0) begin
        checks++;
        if (obs_pcn !== (SKID ? 13'd6 : 13'd5)) begin
          failures++;
          $display("FAIL stall_pcnext got=%h exp=%h", obs_pcn, SKID ? 13'd6 : 13'd5);
        end
      end
      checks++;
      if (bus.ifid_instr !== sv_instr || bus.ifid_pc !== sv_pc || bus.ifid_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_frozen got=%b/%h/%h exp=1/%h/%h", bus.ifid_valid,
                 bus.ifid_instr, bus.ifid_pc, sv_instr, sv_pc);
      end
      bus.pc_in = last_pcn;
    end
    bus.stall = 1'b0;
    tick("stall_release");
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 16'h1234 || bus.ifid_pc !== 13'd5) begin
      failures++;
      $display("FAIL stall_release got=%b/%h/%h exp=1/1234/0005", bus.ifid_valid, bus.ifid_instr, bus.ifid_pc);
    end
    drive(1'b1, last_pcn, 1'b0, 16'h0000, 1'b0, 1'b0, 13'd0);
    tick("stall_after");
    checks++;
    if (obs_req !== 1'b1) begin
      failures++;
      $display("FAIL stall_req_after got=%b exp=1", obs_req);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 13'd7, 1'b1, 16'hBEEF, 1'b1, 1'b1, 13'h0040);
    tick("flush");
    checks++;
    if (obs_pcn !== 13'h0040 || bus.ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush got pcn=%h valid=%b exp pcn=0040 valid=0", obs_pcn, bus.ifid_valid);
    end
    drive(1'b1, 13'h0040, 1'b0, 16'h0000, 1'b0, 1'b0, 13'd0);
    tick("flush_after");
    checks++;
    if (obs_req !== 1'b1 || bus.ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_state got req=%b valid=%b exp req=1 valid=0", obs_req, bus.ifid_valid);
    end
  endtask

  task automatic test_delayed_ack();
    drive(1'b1, 13'h0100, 1'b0, 16'hC0DE, 1'b0, 1'b0, 13'd0);
    for (int i = 0; i < 3; i++) begin
      tick("delay_wait");
      checks++;
      if (obs_req !== 1'b1 || obs_pcn !== 13'h0100) begin
        failures++;
        $display("FAIL delay_wait got req=%b pcn=%h exp req=1 pcn=0100", obs_req, obs_pcn);
      end
    end
    bus.imem_ack = 1'b1;
    tick("delay_ack");
    checks++;
    if (obs_pcn !== 13'h0101 || bus.ifid_instr !== 16'hC0DE || bus.ifid_pc !== 13'h0100) begin
      failures++;
      $display("FAIL delay_ack got pcn=%h ifid=%h/%h exp 0101 c0de/0100", obs_pcn, bus.ifid_instr, bus.ifid_pc);
    end
  endtask

  task automatic test_start_low();
    logic [15:0] sv_instr;
    sv_instr = bus.ifid_instr;
    drive(1'b0, 13'h0222, 1'b1, 16'h7777, 1'b0, 1'b0, 13'd0);
    tick("start_low");
    checks++;
    if (obs_pcn !== 13'h0222 || bus.ifid_instr !== sv_instr || bus.ifid_valid !== 1'b1) begin
      failures++;
      $display("FAIL start_low got pcn=%h instr=%h v=%b exp 0222 %h 1", obs_pcn, bus.ifid_instr, bus.ifid_valid, sv_instr);
    end
    tick("start_low_idle");
    checks++;
    if (obs_req !== 1'b0) begin
      failures++;
      $display("FAIL start_low_idle got req=%b exp=0", obs_req);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 13'h0300, 1'b0, 16'h0000, 1'b0, 1'b0, 13'd0);
    tick("rmid_go");
    reset = 1'b0;
    tick("rmid_reset");
    reset = 1'b1;
    drive(1'b0, 13'h0300, 1'b1, 16'h9999, 1'b0, 1'b0, 13'd0);
    tick("rmid_late_ack");
    checks++;
    if (obs_req !== 1'b0 || bus.ifid_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid got req=%b valid=%b exp req=0 valid=0", obs_req, bus.ifid_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      drive(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 4) != 0) ? last_pcn : 13'($urandom),
            ($urandom_range(0, 9) < 6), 16'($urandom),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), 13'($urandom));
      tick("random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_st = M_IDLE; m_v = 1'b0; m_instr = 16'h0000; m_pc = 13'd0; m_bv = 1'b0;
    m_binstr = 16'h0000; m_bpc = 13'd0; last_pcn = 13'd0;
    test_reset();
    test_first_fetch();
    test_wrap();
    test_stall();
    test_flush();
    test_delayed_ack();
    test_start_low();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly downstream of the program counter register. It takes the current PC, issues a single-beat request to instruction memory, and loads the returned word into the IF/ID pipeline register. It computes the next-PC value fed back to the PC register's input, honouring stalls from the hazard unit and branch redirects from EX.

## Interface
- ADDR_W, 13, instruction address width; matches the PC register width.
- INSTR_W, 16, instruction word width.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- start  in  1  fetch enable; same signal that enables the PC register.
- pc_in  in  ADDR_W  current PC from the PC register.
- pc_next  out  ADDR_W  combinational next PC, driven to the PC register input.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; equals pc_in.
- imem_ack  in  1  response valid; imem_rdata valid in the same cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- stall  in  1  ID cannot accept; the IF/ID register holds its contents.
- flush  in  1  branch taken in EX; redirect fetch.
- br_target  in  ADDR_W  redirect address, valid with flush.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  INSTR_W  IF/ID instruction.
- ifid_pc  out  ADDR_W  address of ifid_instr.

## Operation
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - imem_req=0; pc_next=pc_in.
  - start=1 moves to REQ.
- REQ:
  - imem_req=1.
  - On imem_ack with stall=0: load IF/ID with {1, imem_rdata, pc_in}; pc_next=pc_in+1; stay in REQ.
  - On imem_ack with stall=1: capture {imem_rdata, pc_in} in the hold buffer; pc_next=pc_in+1; move to HOLD.
  - No ack: pc_next=pc_in.
- HOLD:
  - imem_req=0; pc_next=pc_in.
  - When stall=0: move the buffer into IF/ID with valid=1, then go to REQ.
- stall=1 freezes all IF/ID fields in every state.
- flush has highest priority in every state:
  - pc_next=br_target.
  - ifid_valid<=0.
  - Hold buffer is discarded.
  - An imem_ack in the same cycle is dropped.
  - Next state is REQ if start=1, else IDLE.
  - flush clears IF/ID even when stall=1.
- start=0 in REQ or HOLD:
  - Next state is IDLE; the hold buffer is discarded.
  - An ack in that cycle is dropped.
  - pc_next=pc_in.
  - IF/ID contents are kept.
- PC arithmetic: pc_in+1 is modulo 2^ADDR_W, so 13'h1FFF wraps to 0.
- Reset:
  - state=IDLE; ifid_valid=0; ifid_instr=0; ifid_pc=0.
  - Hold buffer cleared; imem_req=0; pc_next=0.
  - Reset asserted mid-request abandons the request; a late ack is ignored because state is IDLE.

## Timing
- imem_ack may arrive in the same cycle as imem_req (combinational memory) or any later cycle.
- Fetch latency: ack cycle N, ifid_instr valid after the clk edge ending cycle N.
- Peak throughput: one instruction per cycle with same-cycle ack and stall=0.
- pc_next is combinational from state, imem_ack, stall, flush, start and pc_in. The PC register samples it on the same edge that IF/ID loads.
- HOLD release: stall falls in cycle M; IF/ID loads at the end of M; the next imem_req is issued in cycle M+1.

## Configuration
- Macro: FETCH_SKID_BUF_EN.
- Defined: the HOLD state and hold buffer exist as described above.
- Undefined:
  - No HOLD state or buffer.
  - imem_ack while stall=1 is discarded; pc_next=pc_in.
  - imem_req stays high and the same address is refetched until stall=0.
  - Costs one refetch per stall; saves ADDR_W+INSTR_W flops.

## Structure
- Package fetch_pkg holds:
  - the state enum (IDLE, REQ, HOLD);
  - default ADDR_W/INSTR_W constants;
  - NOP encoding 16'h0000, used as the ifid_instr value while invalid after reset.
- One sub-module: fetch_skid_buf, the hold buffer with load/clear/valid.
  - Instantiated only under FETCH_SKID_BUF_EN.

## Test plan
- Reset held low 2 cycles, then start=1, pc_in=0, same-cycle ack with rdata=16'hA001 → next cycle ifid_valid=1, ifid_instr=16'hA001, ifid_pc=0; pc_next was 1.
- pc_in=13'h1FFF with ack → pc_next=0 (wrap).
- Ack with rdata=16'h1234, pc_in=5 while stall=1 for 3 cycles:
  - IF/ID is unchanged throughout; pc_next=6 in the ack cycle.
  - After stall falls: ifid_instr=16'h1234, ifid_pc=5.
  - Without the macro: pc_next=5 and address 5 is refetched.
- flush=1, br_target=13'h0040 coincident with ack and stall=1 → pc_next=13'h0040, ifid_valid=0 next cycle, ack data dropped, state REQ.
- Ack delayed 3 cycles → imem_req stays high and pc_next=pc_in until the ack cycle.
- Reset low during REQ with a later ack → ifid_valid stays 0, imem_req=0, state IDLE.
